sg_sample_framer: RTL
=====================

// Module: sg_sample_framer
// PURPOSE
//  Downstream stage of the SG2 signal generator. Captures the free-running sample stream
//  into a small FIFO while armed. Emits fixed-length frames (header, payload, optional
//  trailer) over a req/rdy handshake to the consumer (DMA/UART bridge).
// PARAMETERS
//  DATA_W     16  sample/output word width; must be >= 16
//  FRAME_LEN  8   payload samples per frame; range 1..FIFO_DEPTH
//  FIFO_DEPTH 16  sample buffer depth; power of two
//  CNT_W      16  width of drop_cnt
// PORTS
//  clk       in   1       system clock, all logic on posedge
//  rst       in   1       synchronous, active-high reset
//  start     in   1       capture enable (level); same signal that starts SG2
//  in_valid  in   1       SG2 sample strobe; there is no backpressure toward SG2
//  in_data   in   DATA_W  SG2 sample
//  req       out  1       output word valid
//  rdy       in   1       consumer ready; a word transfers when req && rdy
//  dat       out  DATA_W  output word
//  sof       out  1       high with the header word
//  eof       out  1       high with the last word of a frame
//  overflow  out  1       sticky: a sample was dropped; cleared only by rst
//  drop_cnt  out  CNT_W   dropped-sample count, saturates at all-ones
// BEHAVIOUR
//  Reset
//   - req, sof, eof, overflow = 0; dat = 0; drop_cnt = 0; seq = 0.
//   - FIFO is emptied. FSM goes to IDLE.
//   - Reset mid-frame aborts the frame with no trailer emitted.
//  Input
//   - When start && in_valid, the sample is written if FIFO count < FIFO_DEPTH.
//   - Otherwise (start && in_valid with count == FIFO_DEPTH) the sample is dropped:
//     overflow <= 1 and drop_cnt increments, saturating.
//   - The full check uses the pre-cycle count. A write is dropped even if a pop
//     happens in the same cycle.
//   - Simultaneous push and pop leaves the count unchanged.
//   - With start = 0, in_valid is ignored.
//   - Deasserting start does not abort framing. Residue below FRAME_LEN stays buffered.
//  FSM: IDLE -> HDR -> PAY -> [TRL] -> IDLE
//   - IDLE: when count >= FRAME_LEN, go to HDR next cycle.
//   - HDR: req = 1, sof = 1, dat = {zero-ext, HDR_MAGIC 8'hA5, seq[7:0]}.
//     On handshake, go to PAY.
//   - PAY: dat = FIFO head. Pop on each handshake. After FRAME_LEN handshakes,
//     go to TRL if enabled, else IDLE.
//   - eof is on the last payload word, or on the trailer word when enabled.
//   - Frame complete: seq increments at the final handshake, wrapping 255 -> 0.
//  Handshake and outputs
//   - req, dat, sof, eof are registered. They are held stable while req && !rdy.
//   - req never drops without a transfer.
//   - Back-to-back transfers at one word per clock are required when rdy is held high.
//   - Latency: sample N completing a frame is written at cycle t; FSM leaves IDLE at
//     t+1; req/sof are high from t+2.
//   - After eof transfers, req = 0 for exactly one cycle (IDLE) before the next header.
// CONFIGURATION
//  SG_FRAMER_CSUM_EN
//   - Defined: TRL state is compiled in. The trailer word is the XOR of all FRAME_LEN
//     payload words. The accumulator clears in HDR and updates on each payload handshake.
//     Frame = FRAME_LEN + 2 words.
//   - Undefined: no TRL state and no accumulator. Frame = FRAME_LEN + 1 words;
//     eof is on the last payload word.
// STRUCTURE
//  sg_pkg
//   - typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} framer_state_t.
//   - localparam HDR_MAGIC = 8'hA5.
//  sg_sync_fifo (sub-module)
//   - Parameterised DATA_W/DEPTH, synchronous, show-ahead head.
//   - Ports: push, pop, din, dout, count. Reset on rst.
//  Top
//   - FSM, payload counter, seq, checksum, and overflow/drop logic.
// TESTING
//  1. rst, start=1, 8 samples 0x0001..0x0008, rdy=1
//     -> header 0x00A5_00 (seq 0), then 1..8.
//     eof on 8 (no CSUM) or trailer 0x0008 (CSUM). sof on header only.
//  2. Same stream with rdy toggling 1/0 every cycle
//     -> identical word sequence; dat/req stable during every stall.
//  3. rdy=0, start=1, 20 samples -> FIFO holds 16; overflow=1; drop_cnt=4.
//     Then rdy=1 -> two complete frames, seq 0 then 1.
//  4. Emit 257 frames -> header seq wraps 0xFF -> 0x00; no extra idle cycles beyond one per frame.
//  5. Assert rst after header + 3 payload words
//     -> next cycle req=0, drop_cnt=0, count=0.
//     Next frame header carries seq 0.
//  6. start=0 with in_valid pulsing -> no FIFO writes, req stays 0, drop_cnt unchanged.

Source files
------------

// File: rtl/sg_pkg.sv
// Shared types and constants for the SG2 sample framer.
package sg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TRL  = 2'd3
    } framer_state_t;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam int unsigned SEQ_W    = 8;

endpackage

// File: rtl/sg_sample_framer_if.sv
// Sample-capture inputs and req/rdy output bus of the framer.
// master: the framer side; slave: the SG2/consumer side.
interface sg_sample_framer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic              rdy;
    logic [DATA_W-1:0] dat;
    logic              sof;
    logic              eof;

    modport master (
        input  start, in_valid, in_data, rdy,
        output req, dat, sof, eof
    );

    modport slave (
        output start, in_valid, in_data, rdy,
        input  req, dat, sof, eof
    );
endinterface

// File: rtl/sg_sync_fifo.sv
// Synchronous show-ahead FIFO. dout is the head entry, dout_nxt the entry behind it,
// so the framer can load the following payload word in the same cycle it pops.
// Caller must not push when full nor pop when empty.
module sg_sync_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [DATA_W-1:0]        dout_nxt,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Pointer and occupancy update; push+pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout     = mem_q[rd_ptr_q];
    assign dout_nxt = mem_q[rd_ptr_q + AW'(1)];
    assign count    = count_q;

endmodule

// File: rtl/sg_sample_framer.sv
// SG2 sample framer: buffers samples while start is high and emits frames of
// header, FRAME_LEN payload words and an optional XOR trailer over req/rdy.
// Build option: define SG_FRAMER_CSUM_EN to append the checksum trailer word.
module sg_sample_framer
    import sg_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FRAME_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    sg_sample_framer_if.master      bus,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_cnt
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = $clog2(FRAME_LEN + 1);
    localparam int          FL = int'(FRAME_LEN);
`ifdef SG_FRAMER_CSUM_EN
    localparam bit PAY_EOF = 1'b0;
`else
    localparam bit PAY_EOF = 1'b1;
`endif
    localparam bit EOF_FIRST_PAY = PAY_EOF && (FL == 1);

    framer_state_t     state_q, state_d;
    logic              req_q, req_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [PW-1:0]     pay_cnt_q, pay_cnt_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
`ifdef SG_FRAMER_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] head, head_nxt;
    logic              xfer_c, full_c, push_c, drop_c, pop_c;

    sg_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_c),
        .pop      (pop_c),
        .din      (bus.in_data),
        .dout     (head),
        .dout_nxt (head_nxt),
        .count    (fifo_count)
    );

    // Capture/drop decision uses the pre-cycle count, independent of any pop.
    always_comb begin
        xfer_c = req_q && bus.rdy;
        full_c = (fifo_count == CW'(FIFO_DEPTH));
        push_c = bus.start && bus.in_valid && !full_c;
        drop_c = bus.start && bus.in_valid && full_c;
        pop_c  = (state_q == PAY) && xfer_c;
    end

    // Sticky overflow flag and saturating drop counter.
    always_comb begin
        overflow_d = overflow_q | drop_c;
        drop_cnt_d = drop_cnt_q;
        if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    // Frame FSM; output registers are loaded with the word for the next state
    // so req/dat/sof/eof change only on a transfer or when leaving IDLE.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        sof_d     = sof_q;
        eof_d     = eof_q;
        dat_d     = dat_q;
        pay_cnt_d = pay_cnt_q;
        seq_d     = seq_q;
`ifdef SG_FRAMER_CSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (fifo_count >= CW'(FRAME_LEN)) begin
                    state_d = HDR;
                    req_d   = 1'b1;
                    sof_d   = 1'b1;
                    eof_d   = 1'b0;
                    dat_d   = DATA_W'({HDR_MAGIC, seq_q});
                end
            end
            HDR: begin
`ifdef SG_FRAMER_CSUM_EN
                csum_d = '0;
`endif
                if (xfer_c) begin
                    state_d   = PAY;
                    sof_d     = 1'b0;
                    eof_d     = EOF_FIRST_PAY;
                    dat_d     = head;
                    pay_cnt_d = '0;
                end
            end
            PAY: begin
                if (xfer_c) begin
`ifdef SG_FRAMER_CSUM_EN
                    csum_d = csum_q ^ dat_q;
`endif
                    if (int'(pay_cnt_q) == FL - 1) begin
`ifdef SG_FRAMER_CSUM_EN
                        state_d = TRL;
                        eof_d   = 1'b1;
                        dat_d   = csum_q ^ dat_q;
`else
                        state_d = IDLE;
                        req_d   = 1'b0;
                        eof_d   = 1'b0;
                        seq_d   = seq_q + SEQ_W'(1);
`endif
                    end else begin
                        pay_cnt_d = pay_cnt_q + PW'(1);
                        dat_d     = head_nxt;
                        eof_d     = PAY_EOF && (int'(pay_cnt_q) + 2 == FL);
                    end
                end
            end
            TRL: begin
`ifdef SG_FRAMER_CSUM_EN
                if (xfer_c) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    eof_d   = 1'b0;
                    seq_d   = seq_q + SEQ_W'(1);
                end
`else
                state_d = IDLE;
                req_d   = 1'b0;
                eof_d   = 1'b0;
`endif
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            dat_q      <= '0;
            pay_cnt_q  <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef SG_FRAMER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            dat_q      <= dat_d;
            pay_cnt_q  <= pay_cnt_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef SG_FRAMER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.req  = req_q;
    assign bus.dat  = dat_q;
    assign bus.sof  = sof_q;
    assign bus.eof  = eof_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
